// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and the
// arithmetic result payload. The decoder and hazard unit use them as well.
package mdu_ctrl_pkg;

  localparam int unsigned MD_OP_W          = 3;
  localparam int unsigned MD_DATA_W        = 32;
  localparam int unsigned MULT_CYCLES_DEF  = 5;
  localparam int unsigned DIV_CYCLES_DEF   = 10;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [MD_DATA_W-1:0] hi;
    logic [MD_DATA_W-1:0] lo;
    logic                 div0;
  } md_res_t;

  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: (op, a, b) -> {hi, lo, div0}.
// Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [MD_OP_W-1:0]   op_i,
  input  logic [MD_DATA_W-1:0] a_i,
  input  logic [MD_DATA_W-1:0] b_i,
  output md_res_t              res_o
);

  logic [2*MD_DATA_W-1:0] prod_s;
  logic [2*MD_DATA_W-1:0] prod_u;
  logic [MD_DATA_W-1:0]   a_mag;
  logic [MD_DATA_W-1:0]   b_mag;
  logic [MD_DATA_W-1:0]   dvnd;
  logic [MD_DATA_W-1:0]   dvsr;
  logic [MD_DATA_W-1:0]   quot;
  logic [MD_DATA_W-1:0]   rem;
  logic                   signed_div;

  assign prod_u = {32'd0, a_i} * {32'd0, b_i};
  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

  assign a_mag      = a_i[31] ? -a_i : a_i;
  assign b_mag      = b_i[31] ? -b_i : b_i;
  assign signed_div = (op_i == MD_DIV);
  assign dvnd       = signed_div ? a_mag : a_i;
  // Zero divisor is replaced so the divider never sees it; div0 suppresses the write.
  assign dvsr       = (b_i == '0) ? 32'd1 : (signed_div ? b_mag : b_i);
  assign quot       = dvnd / dvsr;
  assign rem        = dvnd % dvsr;

  always_comb begin
    res_o      = '0;
    res_o.div0 = md_is_div(op_i) && (b_i == '0);
    case (op_i)
      MD_MULT:  {res_o.hi, res_o.lo} = prod_s;
      MD_MULTU: {res_o.hi, res_o.lo} = prod_u;
      MD_DIV: begin
        res_o.lo = (a_i[31] ^ b_i[31]) ? -quot : quot;
        res_o.hi = a_i[31] ? -rem : rem;
      end
      MD_DIVU: begin
        res_o.lo = quot;
        res_o.hi = rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency busy sequencer,
// mfhi/mflo read path and the md_stall request to the hazard unit.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MD_OP_W-1:0]   E_md_op,
  input  logic [MD_DATA_W-1:0] E_rs_data,
  input  logic [MD_DATA_W-1:0] E_rt_data,
  input  logic                 E_mf_sel,
  input  logic                 D_is_md,
  output logic                 E_start,
  output logic                 busy,
  output logic                 md_stall,
  output logic [MD_DATA_W-1:0] HI,
  output logic [MD_DATA_W-1:0] LO,
  output logic [MD_DATA_W-1:0] E_md_rdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e            state_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [MD_OP_W-1:0]   op_q;
  logic [MD_DATA_W-1:0] rs_q;
  logic [MD_DATA_W-1:0] rt_q;
  logic [MD_DATA_W-1:0] hi_q;
  logic [MD_DATA_W-1:0] lo_q;
  md_res_t              res;

  // Result depends only on the operands latched at start.
  mdu_arith u_arith (
    .op_i  (op_q),
    .a_i   (rs_q),
    .b_i   (rt_q),
    .res_o (res)
  );

  assign E_start    = md_is_start(E_md_op);
  assign busy       = busy_q;
  assign md_stall   = D_is_md & (E_start | busy_q);
  assign HI         = hi_q;
  assign LO         = lo_q;
  assign E_md_rdata = E_mf_sel ? hi_q : lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (E_start) begin
            op_q    <= E_md_op;
            rs_q    <= E_rs_data;
            rt_q    <= E_rt_data;
            cnt_q   <= md_is_div(E_md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end else if (E_md_op == MD_MTHI) begin
            hi_q <= E_rs_data;
          end else if (E_md_op == MD_MTLO) begin
            lo_q <= E_rs_data;
          end
        end
        S_BUSY: begin
          // Ops presented while busy are dropped; md_stall keeps them out anyway.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (!res.div0) begin
              hi_q <= res.hi;
              lo_q <= res.lo;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against a 64-bit arithmetic
// reference model of the HI/LO results and the fixed busy latency.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        E_mf_sel;
  logic        D_is_md;
  logic        E_start;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_md_rdata;

  int          n_checks;
  int          n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_rs_data  (E_rs_data),
    .E_rt_data  (E_rt_data),
    .E_mf_sel   (E_mf_sel),
    .D_is_md    (D_is_md),
    .E_start    (E_start),
    .busy       (busy),
    .md_stall   (md_stall),
    .HI         (HI),
    .LO         (LO),
    .E_md_rdata (E_md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void ref_md(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    case (op)
      1: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = 64'(sa * sb);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      2: begin
        p = {32'd0, a} * {32'd0, b};
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      3: if (b != 0) begin
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        exp_lo = q[31:0];
        exp_hi = r[31:0];
      end
      4: if (b != 0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      5: exp_hi = a;
      6: exp_lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic inject);
    int          n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    n      = (op == 1 || op == 2) ? MULT_N : DIV_N;
    old_hi = exp_hi;
    old_lo = exp_lo;
    @(negedge clk);
    E_md_op   = 3'(op);
    E_rs_data = a;
    E_rt_data = b;
    D_is_md   = dmd;
    #1;
    chk("E_start", 32'(E_start), 32'd1);
    chk("md_stall_issue", 32'(md_stall), 32'(dmd));
    ref_md(op, a, b);
    @(negedge clk);
    E_md_op   = 3'd0;
    E_rs_data = $urandom;
    E_rt_data = $urandom;
    for (int i = 1; i <= n; i++) begin
      #1;
      chk("busy_high", 32'(busy), 32'd1);
      chk("md_stall_busy", 32'(md_stall), 32'(dmd));
      if (i == 1) begin
        chk("hi_old", HI, old_hi);
        chk("lo_old", LO, old_lo);
        E_mf_sel = 1'b1;
        #1 chk("rdata_old", E_md_rdata, old_hi);
      end
      if (inject && i == 2) begin
        E_md_op   = 3'($urandom_range(1, 6));
        E_rs_data = $urandom;
        E_rt_data = $urandom;
      end
      if (i == 3) E_md_op = 3'd0;
      @(negedge clk);
    end
    #1;
    chk("busy_low", 32'(busy), 32'd0);
    chk("md_stall_done", 32'(md_stall), 32'd0);
    chk("hi_result", HI, exp_hi);
    chk("lo_result", LO, exp_lo);
    E_mf_sel = 1'b0;
    #1 chk("rdata_lo", E_md_rdata, exp_lo);
    D_is_md = 1'b0;
  endtask

  task automatic mt(input int op, input logic [31:0] a);
    @(negedge clk);
    E_md_op   = 3'(op);
    E_rs_data = a;
    #1 chk("E_start_mt", 32'(E_start), 32'd0);
    ref_md(op, a, 32'd0);
    @(negedge clk);
    E_md_op = 3'd0;
    #1;
    chk("busy_mt", 32'(busy), 32'd0);
    chk("hi_mt", HI, exp_hi);
    chk("lo_mt", LO, exp_lo);
    E_mf_sel = 1'b1;
    #1 chk("rdata_hi_mt", E_md_rdata, exp_hi);
    E_mf_sel = 1'b0;
    #1 chk("rdata_lo_mt", E_md_rdata, exp_lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    n_checks  = 0;
    n_err     = 0;
    exp_hi    = '0;
    exp_lo    = '0;
    reset     = 1'b1;
    E_md_op   = 3'd0;
    E_rs_data = '0;
    E_rt_data = '0;
    E_mf_sel  = 1'b0;
    D_is_md   = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("t1_hi", HI, 32'hFFFF_FFFF);
    chk("t1_lo", LO, 32'hFFFF_FFF1);
    run_op(4, 32'd7, 32'd2, 1'b1, 1'b0);
    chk("t2_divu_lo", LO, 32'd3);
    chk("t2_divu_hi", HI, 32'd1);
    run_op(3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    chk("t2_div_lo", LO, 32'hFFFF_FFFD);
    chk("t2_div_hi", HI, 32'hFFFF_FFFF);
    mt(5, 32'h1234_5678);
    mt(6, 32'h0000_0009);
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);
    mt(5, 32'h0000_000A);
    mt(6, 32'h0000_000B);
    run_op(3, 32'd5, 32'd0, 1'b1, 1'b1);
    chk("div0_hi", HI, 32'h0000_000A);
    chk("div0_lo", LO, 32'h0000_000B);

    // Reset in the third busy cycle of a MULT.
    @(negedge clk);
    E_md_op   = 3'd1;
    E_rs_data = 32'h0001_0000;
    E_rt_data = 32'h0001_0000;
    @(negedge clk);
    E_md_op = 3'd0;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("t6_lo", LO, 32'd6);

    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(1, 6);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if (op >= 5) mt(op, a);
      else run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
